// File: rtl/uart_tx_fifo.sv
// ---------------------------------------------------------------------------
// uart_tx_fifo
//
// Transmit-side byte queue sitting directly in front of the uart core.
// Bus/CPU logic pushes bytes at full clock rate; the block buffers them in a
// circular FIFO and hands them to the UART one at a time through the UART's
// transmit / tx_byte / is_transmitting handshake.
//
// Parameters
//   DEPTH_LOG2     FIFO holds 2**DEPTH_LOG2 bytes.
//   START_TIMEOUT  clk cycles to wait for uart_is_transmitting to rise after
//                  a launch before the byte is abandoned.
//
// Ports
//   clk                   clock
//   rst                   synchronous, active-high reset
//   wr_en / wr_data       push one byte this cycle
//   flush                 discard every queued, not-yet-launched byte
//   full / empty / level  occupancy, decoded from the registered level count
//   overflow              one-cycle pulse: a write was dropped because full
//   launch_err            one-cycle pulse: UART never accepted a launched byte
//   busy                  bytes queued or a handshake in progress
//   uart_transmit         to UART transmit, registered one-cycle pulse
//   uart_tx_byte          to UART tx_byte, held from one pop to the next
//   uart_is_transmitting  from UART is_transmitting
// ---------------------------------------------------------------------------
module uart_tx_fifo #(
  parameter int DEPTH_LOG2    = 4,
  parameter int START_TIMEOUT = 15
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [7:0]            wr_data,
  input  logic                  flush,
  output logic                  full,
  output logic                  empty,
  output logic [DEPTH_LOG2:0]   level,
  output logic                  overflow,
  output logic                  launch_err,
  output logic                  busy,
  output logic                  uart_transmit,
  output logic [7:0]            uart_tx_byte,
  input  logic                  uart_is_transmitting
);

  localparam int DEPTH   = 1 << DEPTH_LOG2;
  localparam int LEVEL_W = DEPTH_LOG2 + 1;
  // The timeout counter only ever holds 0..START_TIMEOUT-1.
  localparam int CNT_W   = (START_TIMEOUT > 1) ? $clog2(START_TIMEOUT) : 1;

  localparam logic [LEVEL_W-1:0]    LEVEL_FULL = LEVEL_W'(DEPTH);
  localparam logic [LEVEL_W-1:0]    LEVEL_ONE  = LEVEL_W'(1);
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE    = DEPTH_LOG2'(1);
  localparam logic [CNT_W-1:0]      CNT_ONE    = CNT_W'(1);
  localparam logic [CNT_W-1:0]      CNT_LAST   = CNT_W'(START_TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    LAUNCH     = 2'd1,
    WAIT_START = 2'd2,
    WAIT_DONE  = 2'd3
  } state_t;

  // -------------------------------------------------------------------------
  // Storage and queue bookkeeping
  // -------------------------------------------------------------------------
  logic [7:0]            mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr_reg;
  logic [DEPTH_LOG2-1:0] rd_ptr_reg;
  logic [LEVEL_W-1:0]    level_reg;
  logic [LEVEL_W-1:0]    level_next;
  logic                  overflow_reg;

  // -------------------------------------------------------------------------
  // Launch FSM state and registered UART-side outputs
  // -------------------------------------------------------------------------
  state_t                state_reg;
  logic [CNT_W-1:0]      cnt_reg;
  logic                  transmit_reg;
  logic                  launch_err_reg;
  logic [7:0]            tx_byte_reg;

  logic                  full_int;
  logic                  empty_int;
  logic                  do_write;
  logic                  drop_write;
  logic                  do_pop;

  assign full_int  = (level_reg == LEVEL_FULL);
  assign empty_int = (level_reg == '0);

  // Flush has priority over a write: the byte is silently discarded and is
  // not reported as an overflow. A write into a full FIFO is dropped even if
  // a pop happens in the same cycle, because fullness is judged on the level
  // at the start of the cycle.
  assign do_write   = wr_en && !full_int && !flush;
  assign drop_write = wr_en &&  full_int && !flush;

  // The head is popped only when the UART is idle. Holding off during a
  // flush keeps a byte that is being discarded from slipping out.
  assign do_pop = (state_reg == IDLE) && !empty_int && !uart_is_transmitting
                  && !flush;

  always_comb begin
    level_next = level_reg;
    if (flush) begin
      level_next = '0;
    end else begin
      case ({do_write, do_pop})
        2'b10:   level_next = level_reg + LEVEL_ONE;
        2'b01:   level_next = level_reg - LEVEL_ONE;
        default: level_next = level_reg;
      endcase
    end
  end

  // Storage array: write port only, no reset so it maps onto block RAM.
  // Contents after reset are irrelevant because level gates every read.
  always_ff @(posedge clk) begin
    if (do_write) begin
      mem[wr_ptr_reg] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      level_reg    <= '0;
      overflow_reg <= 1'b0;
    end else begin
      level_reg    <= level_next;
      overflow_reg <= drop_write;
      if (do_write) begin
        wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
      end
      // Flush empties the queue by snapping the read side onto the write
      // side; nothing is written during a flush so wr_ptr is stable here.
      if (flush) begin
        rd_ptr_reg <= wr_ptr_reg;
      end else if (do_pop) begin
        rd_ptr_reg <= rd_ptr_reg + PTR_ONE;
      end
    end
  end

  // -------------------------------------------------------------------------
  // Launch FSM
  //   IDLE       -> pop head into tx_byte, raise transmit for the next cycle
  //   LAUNCH     -> transmit is high in this cycle only; clear the counter
  //   WAIT_START -> wait for the UART to start, give up after START_TIMEOUT
  //   WAIT_DONE  -> wait for the UART frame to finish
  // A flush never disturbs an in-flight handshake. Reset drops straight to
  // IDLE, and IDLE itself waits for !uart_is_transmitting, so a frame the
  // UART is still sending after reset is never collided with.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= IDLE;
      cnt_reg        <= '0;
      transmit_reg   <= 1'b0;
      launch_err_reg <= 1'b0;
      tx_byte_reg    <= 8'h00;
    end else begin
      transmit_reg   <= 1'b0;
      launch_err_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (do_pop) begin
            // Registered read of the head entry.
            tx_byte_reg  <= mem[rd_ptr_reg];
            transmit_reg <= 1'b1;
            state_reg    <= LAUNCH;
          end
        end
        LAUNCH: begin
          cnt_reg   <= '0;
          state_reg <= WAIT_START;
        end
        WAIT_START: begin
          if (uart_is_transmitting) begin
            state_reg <= WAIT_DONE;
          end else if (cnt_reg == CNT_LAST) begin
            // START_TIMEOUT cycles spent waiting: abandon the byte, it is
            // not retried.
            launch_err_reg <= 1'b1;
            state_reg      <= IDLE;
          end else begin
            cnt_reg <= cnt_reg + CNT_ONE;
          end
        end
        WAIT_DONE: begin
          if (!uart_is_transmitting) begin
            state_reg <= IDLE;
          end
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  assign full          = full_int;
  assign empty         = empty_int;
  assign level         = level_reg;
  assign overflow      = overflow_reg;
  assign launch_err    = launch_err_reg;
  assign busy          = !empty_int || (state_reg != IDLE);
  assign uart_transmit = transmit_reg;
  assign uart_tx_byte  = tx_byte_reg;

endmodule
